// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - Program-load stream, status and fetch-port bundle for imem_loader.
interface imem_loader_if #(
    parameter int N = 32
);
    logic         start;
    logic [6:0]   len;
    logic [7:0]   rx_data;
    logic         rx_valid;
    logic         rx_ready;
    logic [5:0]   addr;
    logic [N-1:0] q;
    logic         busy;
    logic         done;
    logic         err;
    logic         core_rst_n;

    modport master (
        output start, len, rx_data, rx_valid, addr,
        input  rx_ready, q, busy, done, err, core_rst_n
    );

    modport slave (
        input  start, len, rx_data, rx_valid, addr,
        output rx_ready, q, busy, done, err, core_rst_n
    );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - Byte-stream loader into a 64-word instruction RAM; holds the core in reset until loaded.
// Optional trailing XOR check byte: IMEM_LOADER_CHECKSUM_EN.
module imem_loader #(
    parameter int N     = 32,
    parameter int DEPTH = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    imem_loader_if.slave bus
);
    localparam int BPW = N / 8;
    localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;
    localparam logic [CW-1:0] LAST_BYTE = CW'(BPW - 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2, S_CHECK = 2'd3} state_t;
`else
    typedef enum logic [1:0] {S_IDLE = 2'd0, S_LOAD = 2'd1, S_DONE = 2'd2} state_t;
`endif

    state_t        state;
    logic [CW-1:0] byte_cnt;
    logic [5:0]    waddr;
    logic [6:0]    len_q;
    logic [N-1:0]  wbuf;
    logic [N-1:0]  wword;
    logic          rx_ready_q;
    logic          busy_q;
    logic          done_q;
    logic          err_q;
    logic          core_rst_n_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]    csum;
`endif

    logic [N-1:0]  mem [DEPTH];

    logic xfer;
    logic word_end;
    logic last_word;
    logic len_ok;

    assign xfer      = bus.rx_valid && rx_ready_q;
    assign word_end  = xfer && (state == S_LOAD) && (byte_cnt == LAST_BYTE);
    assign last_word = ({1'b0, waddr} == (len_q - 7'd1));
    assign len_ok    = (bus.len != 7'd0) && (bus.len <= 7'd64);

    // The incoming byte is merged combinationally so the word can be written on the edge that accepts it.
    always_comb begin
        wword = wbuf;
        wword[8*byte_cnt +: 8] = bus.rx_data;
    end

    always_ff @(posedge clk) begin
        if (word_end) begin
            mem[waddr] <= wword;
        end
    end

    assign bus.q          = mem[bus.addr];
    assign bus.rx_ready   = rx_ready_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.core_rst_n = core_rst_n_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            byte_cnt     <= '0;
            waddr        <= '0;
            len_q        <= '0;
            wbuf         <= '0;
            rx_ready_q   <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            core_rst_n_q <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum         <= '0;
`endif
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        done_q       <= 1'b0;
                        core_rst_n_q <= 1'b0;
                        if (len_ok) begin
                            state      <= S_LOAD;
                            err_q      <= 1'b0;
                            rx_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                            byte_cnt   <= '0;
                            waddr      <= '0;
                            wbuf       <= '0;
                            len_q      <= bus.len;
`ifdef IMEM_LOADER_CHECKSUM_EN
                            csum       <= '0;
`endif
                        end else begin
                            state <= S_IDLE;
                            err_q <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        csum <= csum ^ bus.rx_data;
`endif
                        if (byte_cnt == LAST_BYTE) begin
                            byte_cnt <= '0;
                            wbuf     <= '0;
                            waddr    <= waddr + 6'd1;
                            if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                                state <= S_CHECK;
`else
                                state        <= S_DONE;
                                rx_ready_q   <= 1'b0;
                                busy_q       <= 1'b0;
                                done_q       <= 1'b1;
                                core_rst_n_q <= 1'b1;
`endif
                            end
                        end else begin
                            wbuf     <= wword;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
`ifdef IMEM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        rx_ready_q <= 1'b0;
                        busy_q     <= 1'b0;
                        if (bus.rx_data == csum) begin
                            state        <= S_DONE;
                            done_q       <= 1'b1;
                            core_rst_n_q <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                            err_q <= 1'b1;
                        end
                    end
                end
`endif
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - Directed self-checking bench for imem_loader with a word-level reference model.
module tb_imem_loader;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    imem_loader_if #(.N(32)) bus ();
    imem_loader #(.N(32), .DEPTH(64)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 0;

    // Reference model: expected status levels and RAM image.
    logic [31:0] mmem [64];
    bit          mknown [64];
    bit e_busy = 0, e_rdy = 0, e_done = 0, e_err = 0, e_core = 0;
    bit          in_words = 0;
    int          len_m = 0, words_m = 0, waddr_m = 0, k_m = 0;
    logic [31:0] acc = '0;
    logic [7:0]  csum_m = '0;
    logic [31:0] wq [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("busy",       {31'd0, bus.busy},       {31'd0, e_busy});
            check("rx_ready",   {31'd0, bus.rx_ready},   {31'd0, e_rdy});
            check("done",       {31'd0, bus.done},       {31'd0, e_done});
            check("err",        {31'd0, bus.err},        {31'd0, e_err});
            check("core_rst_n", {31'd0, bus.core_rst_n}, {31'd0, e_core});
            if (mknown[bus.addr]) check("q", bus.q, mmem[bus.addr]);
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        e_busy = 0; e_rdy = 0; e_done = 0; e_err = 0; e_core = 0; in_words = 0;
    endtask

    task automatic finish_ok();
        e_busy = 0; e_rdy = 0; e_done = 1; e_core = 1;
    endtask

    task automatic model_accept(input logic [7:0] b);
        if (!e_rdy) return;
        if (in_words) begin
            acc[8*k_m +: 8] = b;
            csum_m = csum_m ^ b;
            k_m++;
            if (k_m == 4) begin
                mmem[waddr_m]   = acc;
                mknown[waddr_m] = 1;
                waddr_m = (waddr_m + 1) % 64;
                k_m = 0;
                acc = '0;
                words_m++;
                if (words_m == len_m) begin
                    in_words = 0;
`ifndef IMEM_LOADER_CHECKSUM_EN
                    finish_ok();
`endif
                end
            end
        end else if (b == csum_m) begin
            finish_ok();
        end else begin
            e_err = 1; e_busy = 0; e_rdy = 0;
        end
    endtask

    task automatic do_start(input int l);
        bus.start = 1'b1;
        bus.len   = 7'(l);
        tick();
        bus.start = 1'b0;
        e_done = 0; e_core = 0;
        if (l < 1 || l > 64) begin
            e_err = 1;
        end else begin
            e_err = 0; e_busy = 1; e_rdy = 1;
            in_words = 1; len_m = l; words_m = 0; waddr_m = 0; k_m = 0;
            acc = '0; csum_m = '0;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        repeat (gap) tick();
        bus.rx_valid = 1'b1;
        bus.rx_data  = b;
        tick();
        bus.rx_valid = 1'b0;
        model_accept(b);
    endtask

    // ck < 0 sends the model's own checksum; otherwise ck is the literal check byte.
    task automatic load_q(input int maxgap, input int ck);
        do_start(wq.size());
        foreach (wq[i]) begin
            for (int k = 0; k < 4; k++) send_byte(wq[i][8*k +: 8], int'($urandom_range(0, maxgap)));
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte((ck < 0) ? csum_m : 8'(ck), 0);
`endif
    endtask

    task automatic peek(input string name, input logic [5:0] a, input logic [31:0] exp);
        bus.addr = a;
        #1;
        check(name, bus.q, exp);
    endtask

    initial begin
        bus.start = 0; bus.len = '0; bus.rx_data = '0; bus.rx_valid = 0; bus.addr = '0;
        foreach (mknown[i]) mknown[i] = 0;
        #2;
        check("reset_rx_ready", {31'd0, bus.rx_ready},   32'd0);
        check("reset_busy",     {31'd0, bus.busy},       32'd0);
        check("reset_done",     {31'd0, bus.done},       32'd0);
        check("reset_core",     {31'd0, bus.core_rst_n}, 32'd0);
        tick();
        rst_n = 1'b1;
        cmp_en = 1;
        tick();

        // Invalid lengths from IDLE
        do_start(0);
        check("len0_err", {31'd0, bus.err}, 32'd1);
        do_start(65);
        check("len65_err", {31'd0, bus.err}, 32'd1);
        check("len65_rdy", {31'd0, bus.rx_ready}, 32'd0);
        bus.rx_valid = 1; bus.rx_data = 8'h77;
        repeat (3) tick();
        bus.rx_valid = 0;

        // Scenario 1 payload; its XOR is 8'h20
        wq = '{32'h00a50533, 32'h00a03023};
        load_q(0, 8'h20);
        tick();
        check("s1_done", {31'd0, bus.done}, 32'd1);
        check("s1_core", {31'd0, bus.core_rst_n}, 32'd1);
        peek("s1_mem0", 6'd0, 32'h00a50533);
        peek("s1_mem1", 6'd1, 32'h00a03023);
        bus.rx_valid = 1; bus.rx_data = 8'hff;
        repeat (3) tick();
        bus.rx_valid = 0;

        // Read-during-write on addr 1
        bus.addr = 6'd1;
        do_start(2);
        send_byte(8'h44, 0); send_byte(8'h33, 0); send_byte(8'h22, 0); send_byte(8'h11, 0);
        send_byte(8'h88, 0); send_byte(8'h77, 0); send_byte(8'h66, 1);
        bus.rx_valid = 1; bus.rx_data = 8'h55;
        @(negedge clk);
        check("rdw_before", bus.q, 32'h00a03023);
        @(posedge clk); #1;
        bus.rx_valid = 0;
        model_accept(8'h55);
        check("rdw_after", bus.q, 32'h55667788);
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_m, 0);
`endif
        tick();

        // Reset after 6 bytes of a len=2 load
        do_start(2);
        send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'hfe, 0); send_byte(8'hca, 0);
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check("mid_rst_busy", {31'd0, bus.busy},       32'd0);
        check("mid_rst_rdy",  {31'd0, bus.rx_ready},   32'd0);
        check("mid_rst_core", {31'd0, bus.core_rst_n}, 32'd0);
        peek("mid_rst_mem0", 6'd0, 32'hcafe0001);
        peek("mid_rst_mem1", 6'd1, 32'h55667788);
        tick();
        rst_n = 1'b1;
        tick();

        // len=13 with random gaps and an ignored start mid-load
        wq.delete();
        for (int i = 0; i < 13; i++) wq.push_back($urandom);
        do_start(13);
        for (int i = 0; i < 13; i++) begin
            for (int k = 0; k < 4; k++) send_byte(wq[i][8*k +: 8], int'($urandom_range(0, 3)));
            if (i == 6) begin
                bus.start = 1; bus.len = 7'd5;
                tick();
                bus.start = 0;
            end
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(csum_m, 2);
`endif
        tick();
        for (int i = 0; i < 13; i++) peek("len13_word", 6'(i), wq[i]);

        // Full-depth load
        wq.delete();
        for (int i = 0; i < 64; i++) wq.push_back(32'h01010101 * i + 32'h5a000000);
        load_q(0, -1);
        tick();
        peek("len64_last", 6'd63, 32'h5a000000 + 32'h01010101 * 63);

`ifdef IMEM_LOADER_CHECKSUM_EN
        wq = '{32'h00a50533, 32'h00a03023};
        load_q(0, 8'h00);
        tick();
        check("ck_bad_err",  {31'd0, bus.err},        32'd1);
        check("ck_bad_done", {31'd0, bus.done},       32'd0);
        check("ck_bad_core", {31'd0, bus.core_rst_n}, 32'd0);
`endif

        repeat (2) tick();
        cmp_en = 0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
